// File: rtl/riscv_rf_wb_pkg.sv
// Shared types and helpers for the register-file writeback arbiter.
// Addresses with the top bit set live in the FP bank; integer x0 is all zeros.
package riscv_rf_wb_pkg;

   localparam int DEF_NREQ       = 4;
   localparam int DEF_ADDR_WIDTH = 6;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int FP_BANK_BIT    = DEF_ADDR_WIDTH - 1;
   localparam int X0_CHK_WIDTH   = 16;

   typedef struct packed {
      logic [DEF_ADDR_WIDTH-1:0] addr;
      logic [DEF_DATA_WIDTH-1:0] data;
   } wb_req_t;

   // Callers zero-extend into the wide argument, so any address width up to 16 works.
   function automatic logic is_x0(input logic [X0_CHK_WIDTH-1:0] addr);
      return addr == '0;
   endfunction

endpackage

// File: rtl/riscv_rf_wb_if.sv
// Bundle between writeback requesters/register file (master) and the arbiter (slave).
// Handshake: a write transfers in the cycle where req_valid_i[i] & req_ready_o[i]; valid,
// addr and data stay stable until ready, valid never waits on ready, ready may look at other valids.
interface riscv_rf_wb_if
   import riscv_rf_wb_pkg::*;
#(
   parameter int NREQ       = DEF_NREQ,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
   logic                       hold_i;
   logic [NREQ-1:0]            req_valid_i;
   logic [NREQ*ADDR_WIDTH-1:0] req_addr_i;
   logic [NREQ*DATA_WIDTH-1:0] req_data_i;
   logic [NREQ-1:0]            req_ready_o;
   logic                       we_a_o;
   logic [ADDR_WIDTH-1:0]      waddr_a_o;
   logic [DATA_WIDTH-1:0]      wdata_a_o;
   logic                       we_b_o;
   logic [ADDR_WIDTH-1:0]      waddr_b_o;
   logic [DATA_WIDTH-1:0]      wdata_b_o;
   logic                       busy_o;

   modport master (
      output hold_i, req_valid_i, req_addr_i, req_data_i,
      input  req_ready_o, we_a_o, waddr_a_o, wdata_a_o,
      input  we_b_o, waddr_b_o, wdata_b_o, busy_o
   );

   modport slave (
      input  hold_i, req_valid_i, req_addr_i, req_data_i,
      output req_ready_o, we_a_o, waddr_a_o, wdata_a_o,
      output we_b_o, waddr_b_o, wdata_b_o, busy_o
   );

endinterface

// File: rtl/riscv_rr_dual_pick.sv
// Combinational round-robin picker selecting up to two requesters per cycle,
// skipping a second candidate that targets the same register as the first.
module riscv_rr_dual_pick
   import riscv_rf_wb_pkg::*;
#(
   parameter int NREQ       = DEF_NREQ,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int IW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0]            valid,
   input  logic [NREQ*ADDR_WIDTH-1:0] addr,
   input  logic [IW-1:0]              rr,
   output logic [NREQ-1:0]            gnt_a,
   output logic [NREQ-1:0]            gnt_b,
   output logic [IW-1:0]              idx_a,
   output logic [IW-1:0]              idx_b
);

   logic [ADDR_WIDTH-1:0] addr_a;
   logic [ADDR_WIDTH-1:0] addr_k;
   logic                  found_a;
   logic                  found_b;
   logic                  same;
   int                    slot;

   always_comb begin
      gnt_a   = '0;
      gnt_b   = '0;
      idx_a   = '0;
      idx_b   = '0;
      addr_a  = '0;
      addr_k  = '0;
      found_a = 1'b0;
      found_b = 1'b0;
      same    = 1'b0;
      slot    = 0;
      for (int k = 0; k < NREQ; k++) begin
         slot = int'(rr) + k;
         if (slot >= NREQ) slot = slot - NREQ;
         addr_k = addr[slot*ADDR_WIDTH +: ADDR_WIDTH];
         // Two x0 writes never collide: neither reaches the register file.
         same = (addr_k == addr_a) && !is_x0(X0_CHK_WIDTH'(addr_k));
         if (valid[slot]) begin
            if (!found_a) begin
               found_a     = 1'b1;
               gnt_a[slot] = 1'b1;
               idx_a       = IW'(slot);
               addr_a      = addr_k;
            end else if (!found_b && !same) begin
               found_b     = 1'b1;
               gnt_b[slot] = 1'b1;
               idx_b       = IW'(slot);
            end
         end
      end
   end

endmodule

// File: rtl/riscv_rf_wb_arbiter.sv
// Shares the two register-file write ports among NREQ writeback requesters with
// rotating priority; write ports are registered and drive the RF pins directly.
module riscv_rf_wb_arbiter
   import riscv_rf_wb_pkg::*;
#(
   parameter int NREQ       = DEF_NREQ,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input logic          clk,
   input logic          rst_n,
   riscv_rf_wb_if.slave bus
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IW-1:0]         rr_q;
   logic [IW-1:0]         rr_d;
   logic [IW-1:0]         last_idx;
   logic [IW-1:0]         idx_a;
   logic [IW-1:0]         idx_b;
   logic [NREQ-1:0]       gnt_a;
   logic [NREQ-1:0]       gnt_b;
   logic                  issue;
   logic                  take_a;
   logic                  take_b;
   logic                  write_a;
   logic                  write_b;
   logic [ADDR_WIDTH-1:0] sel_addr_a;
   logic [ADDR_WIDTH-1:0] sel_addr_b;
   logic [DATA_WIDTH-1:0] sel_data_a;
   logic [DATA_WIDTH-1:0] sel_data_b;

   riscv_rr_dual_pick #(
      .NREQ       (NREQ),
      .ADDR_WIDTH (ADDR_WIDTH),
      .IW         (IW)
   ) u_pick (
      .valid (bus.req_valid_i),
      .addr  (bus.req_addr_i),
      .rr    (rr_q),
      .gnt_a (gnt_a),
      .gnt_b (gnt_b),
      .idx_a (idx_a),
      .idx_b (idx_b)
   );

   // No grant may be seen by a requester while reset is asserted or the pipe is held.
   assign issue  = rst_n & ~bus.hold_i;
   assign take_a = issue & (|gnt_a);
   assign take_b = issue & (|gnt_b);

   assign bus.req_ready_o = issue ? (gnt_a | gnt_b) : '0;
   assign bus.busy_o      = |(bus.req_valid_i & ~bus.req_ready_o);

   assign sel_addr_a = bus.req_addr_i[int'(idx_a)*ADDR_WIDTH +: ADDR_WIDTH];
   assign sel_addr_b = bus.req_addr_i[int'(idx_b)*ADDR_WIDTH +: ADDR_WIDTH];
   assign sel_data_a = bus.req_data_i[int'(idx_a)*DATA_WIDTH +: DATA_WIDTH];
   assign sel_data_b = bus.req_data_i[int'(idx_b)*DATA_WIDTH +: DATA_WIDTH];

   assign write_a = take_a & ~is_x0(X0_CHK_WIDTH'(sel_addr_a));
   assign write_b = take_b & ~is_x0(X0_CHK_WIDTH'(sel_addr_b));

   assign last_idx = take_b ? idx_b : idx_a;
   assign rr_d     = (int'(last_idx) == NREQ - 1) ? '0 : last_idx + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q          <= '0;
         bus.we_a_o    <= 1'b0;
         bus.waddr_a_o <= '0;
         bus.wdata_a_o <= '0;
         bus.we_b_o    <= 1'b0;
         bus.waddr_b_o <= '0;
         bus.wdata_b_o <= '0;
      end else begin
         if (take_a) rr_q <= rr_d;
         bus.we_a_o <= write_a;
         bus.we_b_o <= write_b;
         if (write_a) begin
            bus.waddr_a_o <= sel_addr_a;
            bus.wdata_a_o <= sel_data_a;
         end
         if (write_b) begin
            bus.waddr_b_o <= sel_addr_b;
            bus.wdata_b_o <= sel_data_b;
         end
      end
   end

endmodule
